pixel_window_fetch: RTL and testbench
=====================================

# pixel_window_fetch

Downstream consumer of the 32x32 local pixel memory: walks every pixel position of the frame in raster order, reads the 3x3 neighbourhood around it through the memory's combinational read port, and zero-pads neighbours that fall off the image edge. Each assembled window goes to the convolution datapath over a valid/ready handshake, with centre coordinates attached.

## Interface
- `PIX_W`, default 48: width of one pixel word, three 16-bit channels: R [15:0], G [31:16], B [47:32].
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a frame pass; sampled only in IDLE.
- `busy`  out  1  high from the first FETCH cycle until `done`.
- `done`  out  1  one-cycle pulse after the final window handshake.
- `read_pixel_signal`  out  1  read enable to pixel memory.
- `read_pixel_addr`  out  16  [9:5] row, [4:0] col, [15:10] driven 0.
- `read_pixel_data`  in  PIX_W  combinational read data from pixel memory.
- `win_valid`  out  1  window available.
- `win_ready`  in  1  consumer accepts the window.
- `win_data`  out  9*PIX_W  tap k at [PIX_W*k +: PIX_W], k = 3*(dr+1)+(dc+1), dr,dc ∈ {-1,0,1}.
- `win_row`, `win_col`  out  5 each  centre coordinates of the presented window.

## Operation
- FSM: IDLE, FETCH, PRESENT.
- IDLE -> FETCH on `start`. Centre starts at (0,0) with tap index 0.
- FETCH issues one tap per cycle in order k=0..8.
  - Neighbour in range (0..31 on both axes): `read_pixel_signal`=1, address = neighbour coordinates. `read_pixel_data` is captured into tap k at the cycle's closing edge.
  - Neighbour out of range: `read_pixel_signal`=0, address 0, tap k loaded with 0.
- After tap 8 is captured: PRESENT, `win_valid`=1.
  - `win_data`, `win_row` and `win_col` are stable while `win_valid`=1 and `win_ready`=0.
  - No reads are issued in PRESENT.
- Handshake (valid & ready at an edge):
  - If the centre is not (31,31): advance the centre (col+1; at col 31 wrap to col 0, row+1) and return to FETCH.
  - If the centre is (31,31): go to IDLE, pulse `done`, drop `busy`.
- `start` is ignored while busy.
- Coordinate arithmetic uses 6-bit signed intermediates, so -1 and 32 detect as out of range. Counters never wrap outside this rule.
- Full frame = 1024 windows.

## Timing
- Reset values: `busy`, `done`, `read_pixel_signal`, `win_valid` = 0; `read_pixel_addr`, `win_data`, `win_row`, `win_col` = 0. State is IDLE.
- `start` high in cycle T: fetch cycles T+1..T+9, `win_valid` high from T+10.
- Consumer with `win_ready` held high: 10 cycles per window (9 fetch + 1 present).
- `win_valid` drops in the cycle after the handshake. The next window's first fetch happens in that same cycle.
- `done` is high exactly one cycle, the cycle after the final handshake. `busy` is low in that cycle.
- Reset asserted mid-frame (any state): immediate return to reset values. No `done` pulse. The next `start` restarts at (0,0).

## Configuration
- `PIXEL_WIN_REUSE_EN` defined: when the centre advances within the same row (col+1, no row wrap), the window shifts left by one column.
  - New column 0 = old column 1, new column 1 = old column 2.
  - Only taps k=2,5,8 are fetched, in 3 FETCH cycles, with the same padding rules.
  - A row wrap and the first window of a frame still take the full 9 taps.
- `PIXEL_WIN_REUSE_EN` undefined: every window takes the full 9 taps.
- Window contents are identical in both builds; only latency differs.

## Test plan
- Reset, then idle 5 cycles: every output stays 0 and `busy`=0.
- Memory model pixel(r,c) = {16'(r+c), 16'(c), 16'(r)}. After `start`, window (0,0):
  - taps 0,1,2,3,6 = 0, tap4 = pixel(0,0), tap8 = pixel(1,1);
  - `win_valid` first high at T+10;
  - exactly 4 reads issued.
- Window at centre (5,7): tap0 = pixel(4,6), tap4 = pixel(5,7), tap8 = pixel(6,8). `win_row`=5, `win_col`=7.
- Hold `win_ready`=0 for 20 cycles at window (3,31):
  - `win_data` is stable and `read_pixel_signal`=0 throughout;
  - taps 2,5,8 = 0;
  - after release, the next window has centre (4,0).
- Full frame with `win_ready`=1:
  - exactly 1024 handshakes and a single `done` pulse;
  - first fetch to final handshake = 10240 cycles without the macro, 4288 cycles (32×10 + 992×4) with `PIXEL_WIN_REUSE_EN`.
- Assert `rst` during the 5th fetch cycle of window (10,10): all outputs return to 0 and no `done` pulse appears. A new `start` produces a first window with centre (0,0).

Source files
------------

// File: rtl/pixel_window_fetch.sv
// pixel_window_fetch
// ------------------
// Walks every centre position of a 32x32 frame in raster order. For each
// centre it reads the 3x3 neighbourhood from the pixel memory's combinational
// read port, one tap per cycle. Neighbours that fall off the image edge are
// zero-padded and are not read. The assembled window is offered to the
// convolution datapath over a valid/ready handshake, together with the
// window's centre coordinates.
//
// Build option:
//   PIXEL_WIN_REUSE_EN - when the centre steps one column to the right within
//   the same row, the two overlapping window columns are shifted left and
//   only the new right-hand column (taps 2,5,8) is fetched. Window contents
//   are the same in both builds; only the latency differs.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   start                begin a frame pass (sampled only while idle)
//   busy                 high from the first fetch cycle until done
//   done                 one-cycle pulse after the final window handshake
//   read_pixel_signal    read enable to the pixel memory
//   read_pixel_addr      {6'b0, row[4:0], col[4:0]}
//   read_pixel_data      combinational read data from the pixel memory
//   win_valid/win_ready  window handshake
//   win_data             tap k at [PIX_W*k +: PIX_W], k = 3*(dr+1)+(dc+1)
//   win_row, win_col     centre coordinates of the presented window

module pixel_window_fetch #(
  parameter int PIX_W = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               read_pixel_signal,
  output logic [15:0]        read_pixel_addr,
  input  logic [PIX_W-1:0]   read_pixel_data,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [9*PIX_W-1:0] win_data,
  output logic [4:0]         win_row,
  output logic [4:0]         win_col
);

`ifdef PIXEL_WIN_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] tap;         // tap index being fetched this cycle
  logic       shift_mode;  // current window only fetches taps 2,5,8

  // Read request for tap k of the window centred at (row,col):
  // {enable, address}. The sum is formed in 6-bit signed arithmetic, so both
  // -1 and 32 show up with bit 5 set and are treated as off-image.
  function automatic logic [16:0] tap_request(input logic [4:0] row,
                                               input logic [4:0] col,
                                               input logic [3:0] k);
    logic signed [5:0] dr;
    logic signed [5:0] dc;
    logic signed [5:0] r;
    logic signed [5:0] c;
    case (k)
      4'd0, 4'd1, 4'd2: dr = -6'sd1;
      4'd3, 4'd4, 4'd5: dr = 6'sd0;
      default:          dr = 6'sd1;
    endcase
    case (k)
      4'd0, 4'd3, 4'd6: dc = -6'sd1;
      4'd1, 4'd4, 4'd7: dc = 6'sd0;
      default:          dc = 6'sd1;
    endcase
    r = $signed({1'b0, row}) + dr;
    c = $signed({1'b0, col}) + dc;
    if (!r[5] && !c[5]) begin
      tap_request = {1'b1, 6'd0, r[4:0], c[4:0]};
    end else begin
      tap_request = 17'd0;
    end
  endfunction

  logic               last_centre;
  logic               same_row;
  logic [4:0]         next_row;
  logic [4:0]         next_col;
  logic [3:0]         first_tap;
  logic [3:0]         step;
  logic [3:0]         next_tap;
  logic [16:0]        req_next_tap;
  logic [16:0]        req_next_win;
  logic [16:0]        req_frame;
  logic [9*PIX_W-1:0] shifted;

  // Next centre, next tap and the read requests that go with them, so the
  // read enable/address can be loaded into registers one cycle ahead.
  always_comb begin
    last_centre = (win_row == 5'd31) && (win_col == 5'd31);
    same_row    = (win_col != 5'd31);
    if (same_row) begin
      next_row = win_row;
      next_col = win_col + 5'd1;
    end else begin
      next_row = win_row + 5'd1;
      next_col = 5'd0;
    end
    if (REUSE && same_row) begin
      first_tap = 4'd2;
    end else begin
      first_tap = 4'd0;
    end
    if (shift_mode) begin
      step = 4'd3;
    end else begin
      step = 4'd1;
    end
    next_tap     = tap + step;
    req_next_tap = tap_request(win_row, win_col, next_tap);
    req_next_win = tap_request(next_row, next_col, first_tap);
    req_frame    = tap_request(5'd0, 5'd0, 4'd0);
  end

  // Window moved one column left: columns 1,2 become columns 0,1. Column 2
  // keeps stale data until it is refetched.
  always_comb begin
    shifted = win_data;
    for (int m = 0; m < 3; m++) begin
      shifted[PIX_W*(3*m) +: PIX_W]   = win_data[PIX_W*(3*m+1) +: PIX_W];
      shifted[PIX_W*(3*m+1) +: PIX_W] = win_data[PIX_W*(3*m+2) +: PIX_W];
    end
  end

  // Frame walker: IDLE -> FETCH (one tap per cycle) -> PRESENT -> FETCH/IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      tap               <= 4'd0;
      shift_mode        <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      read_pixel_signal <= 1'b0;
      read_pixel_addr   <= 16'd0;
      win_valid         <= 1'b0;
      win_data          <= {(9*PIX_W){1'b0}};
      win_row           <= 5'd0;
      win_col           <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state             <= FETCH;
            busy              <= 1'b1;
            win_row           <= 5'd0;
            win_col           <= 5'd0;
            tap               <= 4'd0;
            shift_mode        <= 1'b0;
            read_pixel_signal <= req_frame[16];
            read_pixel_addr   <= req_frame[15:0];
          end
        end
        FETCH: begin
          // Off-image taps carry no read enable and are loaded with zero.
          if (read_pixel_signal) begin
            win_data[PIX_W*int'(tap) +: PIX_W] <= read_pixel_data;
          end else begin
            win_data[PIX_W*int'(tap) +: PIX_W] <= {PIX_W{1'b0}};
          end
          if (tap == 4'd8) begin
            state             <= PRESENT;
            win_valid         <= 1'b1;
            read_pixel_signal <= 1'b0;
            read_pixel_addr   <= 16'd0;
          end else begin
            tap               <= next_tap;
            read_pixel_signal <= req_next_tap[16];
            read_pixel_addr   <= req_next_tap[15:0];
          end
        end
        PRESENT: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            if (last_centre) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state             <= FETCH;
              win_row           <= next_row;
              win_col           <= next_col;
              tap               <= first_tap;
              shift_mode        <= REUSE && same_row;
              read_pixel_signal <= req_next_win[16];
              read_pixel_addr   <= req_next_win[15:0];
              if (REUSE && same_row) begin
                win_data <= shifted;
              end
            end
          end
        end
        default: begin
          state             <= IDLE;
          busy              <= 1'b0;
          win_valid         <= 1'b0;
          read_pixel_signal <= 1'b0;
          read_pixel_addr   <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_window_fetch.sv
// Self-checking bench for pixel_window_fetch: a pixel memory array with a
// combinational read port, a behavioural window model, a table of hand-derived
// tap values, and sequences for backpressure, full-frame timing and reset.
module tb_pixel_window_fetch;
  localparam int PIX_W = 48;
  localparam int WIN_W = 9 * PIX_W;
`ifdef PIXEL_WIN_REUSE_EN
  localparam int EXP_SPAN  = 4288;
  localparam int RST_FETCH = 2;
`else
  localparam int EXP_SPAN  = 10240;
  localparam int RST_FETCH = 5;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy;
  logic             done;
  logic             read_pixel_signal;
  logic [15:0]      read_pixel_addr;
  logic [PIX_W-1:0] read_pixel_data;
  logic             win_valid;
  logic             win_ready;
  logic [WIN_W-1:0] win_data;
  logic [4:0]       win_row;
  logic [4:0]       win_col;

  logic [PIX_W-1:0] mem [0:1023];
  assign read_pixel_data = mem[read_pixel_addr[9:0]];

  pixel_window_fetch #(.PIX_W(PIX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .read_pixel_signal(read_pixel_signal), .read_pixel_addr(read_pixel_addr),
    .read_pixel_data(read_pixel_data), .win_valid(win_valid),
    .win_ready(win_ready), .win_data(win_data), .win_row(win_row),
    .win_col(win_col)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int viol = 0;
  logic [WIN_W-1:0] win_store [0:1023];

  typedef struct {
    int r;
    int c;
    int k;
    logic [PIX_W-1:0] exp;
  } vec_t;
  vec_t vecs [0:20];

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_pix(input string name, input logic [PIX_W-1:0] act, input logic [PIX_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and tally read/done/protocol events.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (done) done_cnt++;
    if (read_pixel_signal) rd_cnt++;
    if (win_valid && read_pixel_signal) viol++;
    if (read_pixel_addr[15:10] != 6'd0) viol++;
    if (!read_pixel_signal && read_pixel_addr != 16'd0) viol++;
  endtask

  function automatic logic [PIX_W-1:0] formula_pixel(input int r, input int c);
    logic [15:0] s;
    logic [15:0] cc;
    logic [15:0] rr;
    s  = 16'(r + c);
    cc = 16'(c);
    rr = 16'(r);
    return {s, cc, rr};
  endfunction

  task automatic fill_formula();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        mem[r*32+c] = formula_pixel(r, c);
  endtask

  task automatic fill_random();
    logic [63:0] t;
    for (int i = 0; i < 1024; i++) begin
      t = {$urandom(), $urandom()};
      mem[i] = t[PIX_W-1:0];
    end
  endtask

  // Expected window: each neighbour inside the image comes from memory,
  // everything else is zero.
  function automatic logic [WIN_W-1:0] model_win(input int r, input int c);
    logic [WIN_W-1:0] w;
    int rr;
    int cc;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      rr = r + k / 3 - 1;
      cc = c + k % 3 - 1;
      if (rr >= 0 && rr < 32 && cc >= 0 && cc < 32)
        w[PIX_W*k +: PIX_W] = mem[rr*32+cc];
    end
    return w;
  endfunction

  task automatic check_idle(input string name);
    chk_int({name, "_ctl"}, int'({busy, done, read_pixel_signal, win_valid}), 0);
    chk_int({name, "_addr_pos"}, int'({read_pixel_addr, win_row, win_col}), 0);
    chk_vec({name, "_data"}, win_data, '0);
  endtask

  // One complete frame pass, checking every presented window against the model.
  task automatic run_frame(input bit rand_ready, input bit hold_test, input bit store);
    int n;
    int t0;
    int guard;
    int hs_cyc;
    bit fresh;
    bit stalled;
    bit busy_ok;
    bit stable_ok;
    bit hold_ok;
    logic [WIN_W-1:0] held;
    n = 0; guard = 0; hs_cyc = 0;
    fresh = 1'b1; stalled = 1'b0; busy_ok = 1'b1; stable_ok = 1'b1;
    held = '0;
    rd_cnt = 0; done_cnt = 0; viol = 0;
    win_ready = 1'b0;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    while (n < 1024 && guard < 60000) begin
      if (!busy) busy_ok = 1'b0;
      if (win_valid) begin
        if (fresh) begin
          if (n == 0) begin
            chk_int("first_valid_cycle", cyc - t0, 10);
            chk_int("first_window_reads", rd_cnt, 4);
          end
          if (hold_test && n == 128) chk_int("after_hold_centre", int'(win_row)*32 + int'(win_col), 4*32);
          chk_int("centre", int'(win_row)*32 + int'(win_col), n);
          chk_vec("window", win_data, model_win(n / 32, n % 32));
          if (store) win_store[n] = win_data;
          fresh = 1'b0;
          if (hold_test && n == 127) begin
            held = win_data;
            hold_ok = 1'b1;
            for (int i = 0; i < 20; i++) begin
              win_ready = 1'b0;
              tick();
              if (win_data !== held || read_pixel_signal || !win_valid) hold_ok = 1'b0;
            end
            chk_int("hold_stable_no_read", int'(hold_ok), 1);
            chk_int("hold_right_col_zero",
                    int'(|{win_data[PIX_W*2 +: PIX_W], win_data[PIX_W*5 +: PIX_W], win_data[PIX_W*8 +: PIX_W]}), 0);
          end
        end else if (stalled && win_data !== held) begin
          stable_ok = 1'b0;
        end
        held = win_data;
        win_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (win_ready) begin
          n++;
          fresh = 1'b1;
          stalled = 1'b0;
          hs_cyc = cyc;
        end else begin
          stalled = 1'b1;
        end
      end else begin
        win_ready = rand_ready ? $urandom_range(0, 1) == 1 : 1'b1;
      end
      tick();
      guard++;
    end
    win_ready = 1'b0;
    chk_int("handshakes", n, 1024);
    if (!rand_ready && !hold_test) chk_int("frame_span", hs_cyc - t0, EXP_SPAN);
    chk_int("done_pulse", int'({done, busy}), 2);
    tick();
    chk_int("done_cleared", int'({done, busy}), 0);
    chk_int("done_count", done_cnt, 1);
    chk_int("busy_during_frame", int'(busy_ok), 1);
    chk_int("stall_stable", int'(stable_ok), 1);
    chk_int("protocol_violations", viol, 0);
  endtask

  initial begin
    logic [WIN_W-1:0] w;
    int fc;
    int guard;

    // Hand-derived taps for the formula memory pixel(r,c) = {r+c, c, r}.
    vecs[0]  = '{0, 0, 0, 48'h0};
    vecs[1]  = '{0, 0, 1, 48'h0};
    vecs[2]  = '{0, 0, 2, 48'h0};
    vecs[3]  = '{0, 0, 3, 48'h0};
    vecs[4]  = '{0, 0, 4, 48'h0000_0000_0000};
    vecs[5]  = '{0, 0, 5, 48'h0001_0001_0000};
    vecs[6]  = '{0, 0, 6, 48'h0};
    vecs[7]  = '{0, 0, 7, 48'h0001_0000_0001};
    vecs[8]  = '{0, 0, 8, 48'h0002_0001_0001};
    vecs[9]  = '{5, 7, 0, 48'h000A_0006_0004};
    vecs[10] = '{5, 7, 4, 48'h000C_0007_0005};
    vecs[11] = '{5, 7, 8, 48'h000E_0008_0006};
    vecs[12] = '{3, 31, 2, 48'h0};
    vecs[13] = '{3, 31, 5, 48'h0};
    vecs[14] = '{3, 31, 8, 48'h0};
    vecs[15] = '{3, 31, 4, 48'h0022_001F_0003};
    vecs[16] = '{31, 31, 8, 48'h0};
    vecs[17] = '{31, 31, 6, 48'h0};
    vecs[18] = '{31, 31, 0, 48'h003C_001E_001E};
    vecs[19] = '{31, 0, 3, 48'h0};
    vecs[20] = '{31, 0, 1, 48'h001E_0000_001E};

    rst = 1'b1;
    start = 1'b0;
    win_ready = 1'b0;
    fill_formula();
    repeat (2) tick();
    check_idle("reset");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("idle");
    end

    // Frame A: consumer always ready; timing, read count, table lookups.
    run_frame(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 21; i++) begin
      w = win_store[vecs[i].r*32 + vecs[i].c];
      chk_pix($sformatf("table_r%0d_c%0d_k%0d", vecs[i].r, vecs[i].c, vecs[i].k),
              w[PIX_W*vecs[i].k +: PIX_W], vecs[i].exp);
    end
    chk_int("table_centre_5_7", int'(win_store[5*32+7][PIX_W*4 +: 16]), 5);

    // Frame B: random backpressure plus a 20-cycle hold at centre (3,31).
    run_frame(1'b1, 1'b1, 1'b0);

    // Frame C: random memory contents with random backpressure.
    fill_random();
    run_frame(1'b1, 1'b0, 1'b0);

    // Reset in the middle of fetching window (10,10).
    fill_formula();
    win_ready = 1'b1;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    fc = 0;
    guard = 0;
    while (fc < RST_FETCH && guard < 20000) begin
      if (busy && !win_valid && win_row == 5'd10 && win_col == 5'd10) fc++;
      if (fc < RST_FETCH) begin
        tick();
        guard++;
      end
    end
    chk_int("reached_fetch_10_10", fc, RST_FETCH);
    rst = 1'b1;
    #1;
    check_idle("async_reset");
    done_cnt = 0;
    repeat (3) tick();
    rst = 1'b0;
    win_ready = 1'b0;
    repeat (3) tick();
    check_idle("after_reset");
    chk_int("no_done_after_reset", done_cnt, 0);
    run_frame(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
